// File: rtl/pl_stage_elastic.sv
// Elastic pipeline-stage register: valid/ready on both sides, optional skid
// entry that registers in_ready, hold/flush controls and a saturating stall counter.
module pl_stage_elastic #(
  parameter int WIDTH = 32,
  parameter int SKID  = 1,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  input  logic             hold,
  input  logic             flush,
  output logic [1:0]       occupancy,
  output logic [CNT_W-1:0] stall_cnt
);

  // Handshake: a payload moves on a side only in a cycle where that side's
  // valid and ready are both high at the rising edge; valid never waits on ready.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] STALL_MAX = '1;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic             in_fire;
  logic             out_fire;

  // With the skid entry, in_ready is a function of registered state only,
  // which breaks the out_ready -> in_ready combinational path.
  always_comb begin
    if (SKID != 0) begin
      in_ready = (state_q != ST_TWO) & ~hold & ~clr;
    end else begin
      in_ready = ((state_q == ST_EMPTY) | out_ready) & ~hold & ~clr;
    end
    out_valid = (state_q != ST_EMPTY) & ~hold;
  end

  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;
  assign out_data  = main_q;
  assign occupancy = state_q;
  assign stall_cnt = stall_q;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = ST_EMPTY;
      main_d  = '0;
      skid_d  = '0;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (in_fire) begin
            state_d = ST_ONE;
            main_d  = in_data;
          end
        end
        ST_ONE: begin
          if (in_fire && out_fire) begin
            main_d = in_data;
          end else if (in_fire) begin
            if (SKID != 0) begin
              state_d = ST_TWO;
              skid_d  = in_data;
            end else begin
              main_d = in_data;
            end
          end else if (out_fire) begin
            state_d = ST_EMPTY;
            main_d  = '0;
          end
        end
        ST_TWO: begin
          if (out_fire) begin
            state_d = ST_ONE;
            main_d  = skid_q;
            skid_d  = '0;
          end
        end
        default: begin
          state_d = ST_EMPTY;
          main_d  = '0;
          skid_d  = '0;
        end
      endcase
    end
  end

  // Hold forces out_valid low, so the counter naturally freezes while held.
  always_comb begin
    stall_d = stall_q;
    if (out_valid && !out_ready && !flush && (stall_q != STALL_MAX)) begin
      stall_d = stall_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= ST_EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
      stall_q <= stall_d;
    end
  end

endmodule

// File: tb/tb_pl_stage_elastic.sv
// Bench for pl_stage_elastic: a SKID=1/CNT_W=4 and a SKID=0 instance share stimulus,
// each checked every cycle against a queue-based model plus directed literal checks.
module tb_pl_stage_elastic;

  logic       clk = 1'b0;
  logic       clr;
  logic       in_valid;
  logic [7:0] in_data;
  logic       out_ready;
  logic       hold;
  logic       flush;

  logic        in_ready1, out_valid1;
  logic [7:0]  out_data1;
  logic [1:0]  occ1;
  logic [3:0]  stall1;
  logic        in_ready0, out_valid0;
  logic [7:0]  out_data0;
  logic [1:0]  occ0;
  logic [15:0] stall0;

  pl_stage_elastic #(.WIDTH(8), .SKID(1), .CNT_W(4)) u_skid (
    .clk(clk), .clr(clr), .in_valid(in_valid), .in_ready(in_ready1), .in_data(in_data),
    .out_valid(out_valid1), .out_ready(out_ready), .out_data(out_data1),
    .hold(hold), .flush(flush), .occupancy(occ1), .stall_cnt(stall1)
  );

  pl_stage_elastic #(.WIDTH(8), .SKID(0), .CNT_W(16)) u_noskid (
    .clk(clk), .clr(clr), .in_valid(in_valid), .in_ready(in_ready0), .in_data(in_data),
    .out_valid(out_valid0), .out_ready(out_ready), .out_data(out_data0),
    .hold(hold), .flush(flush), .occupancy(occ0), .stall_cnt(stall0)
  );

  always #5 clk = ~clk;

  logic [7:0] exp_q1[$];
  logic [7:0] exp_q0[$];
  int         cnt1;
  int         cnt0;
  bit         known;
  int         checks;
  int         failures;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s t=%0t actual=%0h required=%0h", nm, $time, act, exp);
    end
  endtask

  function automatic bit exp_ir(input bit skid, input int sz);
    if (skid) return (sz < 2) && !hold && !clr;
    return ((sz == 0) || out_ready) && !hold && !clr;
  endfunction

  // Compare both instances against the model, then advance the model by
  // the edge that follows (inputs are stable from here to that edge).
  task automatic model_step();
    int         sz1, sz0;
    bit         ov1, ov0, ir1, ir0;
    logic [7:0] h1, h0;
    sz1 = exp_q1.size();
    sz0 = exp_q0.size();
    ov1 = (sz1 > 0) && !hold;
    ov0 = (sz0 > 0) && !hold;
    ir1 = exp_ir(1'b1, sz1);
    ir0 = exp_ir(1'b0, sz0);
    h1  = (sz1 > 0) ? exp_q1[0] : 8'h00;
    h0  = (sz0 > 0) ? exp_q0[0] : 8'h00;
    if (known) begin
      chk("skid_in_ready", in_ready1, ir1);
      chk("skid_out_valid", out_valid1, ov1);
      chk("skid_out_data", out_data1, h1);
      chk("skid_occupancy", occ1, sz1);
      chk("skid_stall_cnt", stall1, cnt1);
      chk("noskid_in_ready", in_ready0, ir0);
      chk("noskid_out_valid", out_valid0, ov0);
      chk("noskid_out_data", out_data0, h0);
      chk("noskid_occupancy", occ0, sz0);
      chk("noskid_stall_cnt", stall0, cnt0);
    end
    if (clr) begin
      exp_q1.delete();
      exp_q0.delete();
      cnt1  = 0;
      cnt0  = 0;
      known = 1'b1;
    end else if (known) begin
      if (flush) begin
        exp_q1.delete();
        exp_q0.delete();
      end else begin
        if (ov1 && !out_ready && cnt1 < 15) cnt1++;
        if (ov0 && !out_ready && cnt0 < 65535) cnt0++;
        if (ov1 && out_ready) void'(exp_q1.pop_front());
        if (ov0 && out_ready) void'(exp_q0.pop_front());
        if (in_valid && ir1) exp_q1.push_back(in_data);
        if (in_valid && ir0) exp_q0.push_back(in_data);
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input bit v, input logic [7:0] d, input bit ordy, input bit h, input bit f);
    in_valid  = v;
    in_data   = d;
    out_ready = ordy;
    hold      = h;
    flush     = f;
  endtask

  task automatic drain(input int n);
    set_in(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    known    = 1'b0;
    cnt1     = 0;
    cnt0     = 0;
    clr      = 1'b1;
    set_in(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    tick();
    tick();
    clr = 1'b0;
    #1;
    chk("reset_out_valid", out_valid1, 1'b0);
    chk("reset_out_data", out_data1, 8'h00);
    chk("reset_occupancy", occ1, 2'd0);
    chk("reset_stall_cnt", stall1, 4'd0);
    chk("reset_in_ready", in_ready1, 1'b1);

    // Streaming at full rate
    for (int i = 1; i <= 10; i++) begin
      set_in(1'b1, 8'(i), 1'b1, 1'b0, 1'b0);
      #1;
      chk("stream_in_ready", in_ready1, 1'b1);
      if (i > 1) chk("stream_out_data", out_data1, 8'(i - 1));
      tick();
    end
    drain(1);
    chk("stream_stall_cnt", stall1, 4'd0);

    // Backpressure into the skid entry
    set_in(1'b1, 8'h0A, 1'b1, 1'b0, 1'b0);
    tick();
    set_in(1'b1, 8'h0B, 1'b0, 1'b0, 1'b0);
    tick();
    set_in(1'b1, 8'h0C, 1'b0, 1'b0, 1'b0);
    tick();
    #1;
    chk("bp_occupancy", occ1, 2'd2);
    chk("bp_in_ready", in_ready1, 1'b0);
    chk("bp_out_data", out_data1, 8'h0A);
    tick();
    set_in(1'b1, 8'h0C, 1'b1, 1'b0, 1'b0);
    #1;
    chk("bp_stall_cnt", stall1, 4'd3);
    tick();
    chk("bp_second_out", out_data1, 8'h0B);
    tick();
    set_in(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    #1;
    chk("bp_third_out", out_data1, 8'h0C);
    drain(4);

    // Combinational ready path without skid
    set_in(1'b1, 8'h21, 1'b1, 1'b0, 1'b0);
    tick();
    set_in(1'b1, 8'h22, 1'b1, 1'b0, 1'b0);
    #1;
    chk("comb_in_ready", in_ready0, 1'b1);
    chk("comb_occupancy", occ0, 2'd1);
    tick();
    set_in(1'b1, 8'h23, 1'b0, 1'b0, 1'b0);
    #1;
    chk("comb_in_ready_low", in_ready0, 1'b0);
    chk("comb_out_data", out_data0, 8'h22);
    tick();
    drain(3);

    // Flush with a full skid stage and an incoming payload
    set_in(1'b1, 8'h11, 1'b0, 1'b0, 1'b0);
    tick();
    set_in(1'b1, 8'h22, 1'b0, 1'b0, 1'b0);
    tick();
    set_in(1'b1, 8'h33, 1'b0, 1'b0, 1'b1);
    #1;
    chk("flush_pre_occupancy", occ1, 2'd2);
    chk("flush_pre_data", out_data1, 8'h11);
    tick();
    set_in(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    #1;
    chk("flush_occupancy", occ1, 2'd0);
    chk("flush_out_valid", out_valid1, 1'b0);
    chk("flush_out_data", out_data1, 8'h00);
    chk("flush_noskid_occ", occ0, 2'd0);
    tick();

    // Hold for three cycles
    set_in(1'b1, 8'h55, 1'b1, 1'b0, 1'b0);
    tick();
    for (int i = 0; i < 3; i++) begin
      set_in(1'b1, 8'h66, 1'b1, 1'b1, 1'b0);
      #1;
      chk("hold_in_ready", in_ready1, 1'b0);
      chk("hold_out_valid", out_valid1, 1'b0);
      tick();
    end
    set_in(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    #1;
    chk("hold_release_valid", out_valid1, 1'b1);
    chk("hold_release_data", out_data1, 8'h55);
    drain(3);

    // Stall counter saturation
    clr = 1'b1;
    tick();
    clr = 1'b0;
    set_in(1'b1, 8'h77, 1'b1, 1'b0, 1'b0);
    tick();
    set_in(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) tick();
    chk("sat_stall_skid", stall1, 4'd15);
    chk("sat_stall_noskid", stall0, 16'd20);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    #1;
    chk("sat_clr_stall", stall1, 4'd0);
    chk("sat_clr_occ", occ1, 2'd0);

    // Randomized traffic with occasional hold, flush and clr
    for (int i = 0; i < 3000; i++) begin
      clr = ($urandom_range(0, 149) == 0);
      set_in($urandom_range(0, 3) != 0, 8'($urandom_range(0, 255)),
             (i % 400 < 200) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0),
             $urandom_range(0, 9) == 0, $urandom_range(0, 24) == 0);
      tick();
    end
    clr = 1'b0;
    drain(4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pl_stage_elastic.md
# pl_stage_elastic

Parametrised elastic pipeline-stage register, the successor to the fixed per-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB). It carries an opaque WIDTH-bit payload between two pipeline stages with valid/ready handshaking on both sides, an optional skid entry that cuts the combinational ready path, and separate hold and flush controls. A saturating counter records backpressure cycles for performance debugging.

## Interface
- WIDTH, 32: payload width in bits; the integrator packs all stage fields into one bus.
- SKID, 1: 1 = two-entry skid buffer with registered in_ready; 0 = single entry with combinational in_ready.
- CNT_W, 16: width of the stall counter.

- clk  input  1  clock; all state updates on posedge.
- clr  input  1  reset; synchronous, active-high.
- in_valid  input  1  upstream has a payload.
- in_ready  output  1  stage accepts a payload this cycle.
- in_data  input  WIDTH  upstream payload.
- out_valid  output  1  stage presents a payload.
- out_ready  input  1  downstream accepts a payload this cycle.
- out_data  output  WIDTH  payload presented downstream.
- hold  input  1  freeze: no transfer on either side, state retained.
- flush  input  1  discard all held payloads and any incoming payload.
- occupancy  output  2  number of valid entries (0, 1 or 2).
- stall_cnt  output  CNT_W  cycles with a payload presented but out_ready low.

## Operation
- Transfers: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- Storage: main entry (drives out_data) and, when SKID=1, a skid entry. Payload registers that become invalid are written to 0.
- State (SKID=1): EMPTY, ONE (main valid), TWO (main and skid valid).
  - EMPTY: in_fire -> ONE, main <= in_data.
  - ONE: in_fire & out_fire -> ONE, main <= in_data. in_fire only -> TWO, skid <= in_data. out_fire only -> EMPTY. Neither -> ONE.
  - TWO: in_ready = 0. out_fire -> ONE, main <= skid, skid <= 0. Otherwise -> TWO.
- State (SKID=0): EMPTY and ONE only, with the same EMPTY/ONE rules and no TWO.
- in_ready, SKID=1: (state != TWO) & !hold & !clr. Depends only on registered state and the hold/clr inputs, never on out_ready.
- in_ready, SKID=0: (state == EMPTY | out_ready) & !hold & !clr.
- out_valid = (state != EMPTY) & !hold. out_data = main; out_data is 0 when EMPTY.
- hold = 1: in_ready = 0 and out_valid = 0, so no transfers occur. State, payloads and stall_cnt are retained.
- flush = 1: next state is EMPTY and main/skid are set to 0. Any in_fire in the same cycle is discarded. Priority is clr > flush > hold > normal.
- occupancy = 0 / 1 / 2 for EMPTY / ONE / TWO.
- stall_cnt: increments when out_valid & !out_ready & !flush, and saturates at 2^CNT_W − 1 without wrapping. Only clr clears it.
- Ordering: payloads leave in the order they were accepted. None is duplicated or dropped, except on flush or clr.

## Timing
- Reset: while clr = 1 at a posedge, next state is EMPTY, main/skid = 0 and stall_cnt = 0. After reset: out_valid = 0, out_data = 0, occupancy = 0, stall_cnt = 0, and in_ready = 1 when hold = 0. in_ready is 0 during any cycle with clr high.
- clr asserted mid-operation discards all held data in the same manner.
- Latency: a payload accepted at edge N is visible on out_data/out_valid after edge N, so it can leave at edge N+1.
- Throughput: one payload per cycle when out_ready is held high, for either SKID value.
- SKID=1 backpressure: when out_ready drops, at most one further payload is absorbed (into skid) before in_ready falls on the next cycle.
- Simultaneous in_fire and out_fire in ONE keeps occupancy at 1 and forwards the new payload next cycle.
- Flush and hold on the same edge: flush wins and the next state is EMPTY. The stage remains frozen while hold stays high.

## Test plan
- Reset and streaming: clr for 2 cycles, then in_valid = 1 with data 1, 2, 3…, out_ready = 1. Required: out_data 1, 2, 3… each one cycle after acceptance, in_ready constant 1, stall_cnt = 0.
- Backpressure (SKID=1): stream 0xA, 0xB, 0xC and drop out_ready after 0xA is presented. Required: 0xB is absorbed into skid, occupancy = 2, in_ready = 0. On releasing out_ready, output is 0xA, 0xB, 0xC in order. stall_cnt equals the number of low out_ready cycles.
- Combinational path (SKID=0): state ONE with out_ready = 1 and in_valid = 1. Required: in_ready = 1 the same cycle and occupancy stays 1.
- Flush: occupancy = 2 (0x11 in main, 0x22 in skid), then assert flush together with in_valid = 1 and data 0x33. Required next cycle: occupancy = 0, out_valid = 0, out_data = 0, and 0x33 never appears.
- Hold: occupancy = 1 (0x55), hold = 1 for 3 cycles with out_ready = 1 and in_valid = 1. Required: in_ready = 0 and out_valid = 0 for 3 cycles, stall_cnt unchanged. 0x55 emerges on the first cycle after hold drops.
- Saturation: CNT_W = 4 and out_ready low for 20 cycles with a payload held. Required: stall_cnt stops at 15. A following clr returns it to 0.
